// File: rtl/cpu_result_capture.sv
// cpu_result_capture: arms on start, captures {over, outsel, result} samples into a show-ahead FIFO.
// Optional macro CAP_TIMESTAMP_EN stores a free-running cycle timestamp with each entry (rd_ts).
module cpu_result_capture #(
    parameter int DW    = 32,
    parameter int DEPTH = 16,
    parameter int CW    = 8,
    parameter int TSW   = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic [CW-1:0]              num_samples,
    input  logic                       stop,
    input  logic                       oen,
    input  logic [2:0]                 outsel,
    input  logic [DW-1:0]              result,
    input  logic                       over,
    output logic                       rd_valid,
    input  logic                       rd_ready,
    output logic [DW-1:0]              rd_result,
    output logic                       rd_over,
    output logic [2:0]                 rd_sel,
`ifdef CAP_TIMESTAMP_EN
    output logic [TSW-1:0]             rd_ts,
`endif
    output logic                       busy,
    output logic                       done,
    output logic [CW-1:0]              dropped,
    output logic [$clog2(DEPTH):0]     level
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
`ifdef CAP_TIMESTAMP_EN
    localparam int EW = DW + 4 + TSW;
`else
    localparam int EW = DW + 4;
`endif

    typedef enum logic [1:0] {IDLE, ARMED, DONE} state_t;

    state_t        state;
    logic [CW-1:0] remaining;
    logic [EW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [EW-1:0] entry, head;
    logic          offer, push, pop, full;

`ifdef CAP_TIMESTAMP_EN
    logic [TSW-1:0] ts;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) ts <= '0;
        else        ts <= ts + 1'b1;
    assign entry = {ts, over, outsel, result};
    assign rd_ts = head[EW-1 -: TSW];
`else
    assign entry = {over, outsel, result};
`endif

    assign offer    = state == ARMED && oen;
    assign full     = level == LW'(DEPTH);
    assign pop      = rd_valid && rd_ready;
    // A pop in the same cycle frees the slot a full FIFO would otherwise lack.
    assign push     = offer && (!full || pop);
    assign rd_valid = level != '0;
    // Gating the head keeps rd_* at zero after reset even though storage is not cleared.
    assign head     = rd_valid ? mem[rd_ptr] : '0;
    assign {rd_over, rd_sel, rd_result} = head[DW+3:0];
    assign busy     = state == ARMED;
    assign done     = state == DONE;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            remaining <= '0;
            dropped   <= '0;
        end else begin
            case (state)
                ARMED: begin
                    if (offer && !push && dropped != '1) dropped <= dropped + 1'b1;
                    if (offer && remaining != '0) remaining <= remaining - 1'b1;
                    if ((offer && remaining == CW'(1)) || stop) state <= DONE;
                end
                default: begin
                    if (start) begin
                        state     <= ARMED;
                        remaining <= num_samples;
                        dropped   <= '0;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      level <= level + 1'b1;
            else if (pop && !push) level <= level - 1'b1;
        end
    end

    always_ff @(posedge clk)
        if (push) mem[wr_ptr] <= entry;

endmodule
